// File: rtl/spi_host_pkg.sv
// Shared types and constants for the SPI host: FSM state encoding and frame width.
package spi_host_pkg;
  localparam int FRAME_W = 8;
  localparam int BIT_W   = $clog2(FRAME_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DESELECT
  } state_t;
endpackage

// File: rtl/spi_host_sck_divider.sv
// Half-period timer: tick marks the last clk cycle of each CLK_DIV-long sck half-period.
module sck_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  logic [7:0] cnt;

  assign tick = (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (tick)      cnt <= '0;
    else                cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/spi_host.sv
// SPI mode-0 host: one address byte followed by num_bytes full-duplex data bytes per chip-select.
module spi_host
  import spi_host_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FRAME_W-1:0] addr,
  input  logic [3:0]         num_bytes,
  input  logic [FRAME_W-1:0] tx_data,
  output logic               tx_ack,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               busy,
  output logic               done,
  output logic               cs,
  output logic               sck,
  output logic               mosi,
  input  logic               miso
);
  state_t             state, state_n;
  logic               tick, div_clear;
  logic [BIT_W-1:0]   bit_cnt;
  logic [3:0]         byte_cnt;
  logic               data_phase;
  logic [FRAME_W-2:0] tx_sh;
  logic [FRAME_W-2:0] rx_sh;
  logic               rise, fall, byte_end, more;

  assign div_clear = (state == IDLE);

  sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear),
    .tick  (tick)
  );

  // The sck flop doubles as the phase indicator inside SHIFT.
  assign rise     = (state == SHIFT) && tick && !sck;
  assign fall     = (state == SHIFT) && tick &&  sck;
  assign byte_end = fall && (bit_cnt == BIT_W'(FRAME_W - 1));
  assign more     = (byte_cnt != 4'd0);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tx_ack   = 1'b0;
    rx_valid = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:     if (start) state_n = SETUP;
      SETUP:    if (tick) state_n = SHIFT;
      SHIFT: begin
        tx_ack   = byte_end && more && !reset;
        rx_valid = byte_end && data_phase && !reset;
        if (byte_end && !more) state_n = HOLD;
      end
      HOLD:     if (tick) state_n = DESELECT;
      DESELECT: if (tick) begin
        done    = !reset;
        state_n = IDLE;
      end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs         <= 1'b1;
      sck        <= 1'b0;
      mosi       <= 1'b0;
      rx_data    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      data_phase <= 1'b0;
      tx_sh      <= '0;
      rx_sh      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cs         <= 1'b0;
          mosi       <= addr[FRAME_W-1];
          tx_sh      <= addr[FRAME_W-2:0];
          byte_cnt   <= num_bytes;
          data_phase <= 1'b0;
          bit_cnt    <= '0;
        end
        SHIFT: begin
          if (rise) begin
            sck   <= 1'b1;
            rx_sh <= {rx_sh[FRAME_W-3:0], miso};
            if (data_phase && bit_cnt == BIT_W'(FRAME_W - 1))
              rx_data <= {rx_sh, miso};
          end
          if (fall) begin
            sck <= 1'b0;
            if (!byte_end) begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              mosi    <= tx_sh[FRAME_W-2];
              tx_sh   <= {tx_sh[FRAME_W-3:0], 1'b0};
            end else begin
              bit_cnt <= '0;
              if (more) begin
                // Next byte goes straight out with no inter-byte gap.
                mosi       <= tx_data[FRAME_W-1];
                tx_sh      <= tx_data[FRAME_W-2:0];
                byte_cnt   <= byte_cnt - 4'd1;
                data_phase <= 1'b1;
              end else begin
                mosi <= 1'b0;
              end
            end
          end
        end
        HOLD: if (tick) cs <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_host.sv
// Scoreboarded bench: two hosts (CLK_DIV 2 and 4) talking to behavioural SPI peripherals.
module tb_spi_host;
  logic       clk = 1'b0;
  logic       reset[2], start[2], miso[2];
  logic       tx_ack[2], rx_valid[2], busy[2], done[2], cs[2], sck[2], mosi[2];
  logic [7:0] addr[2], tx_data[2], rx_data[2];
  logic [3:0] num_bytes[2];

  logic [7:0] exp_mosi[2][$];
  logic [7:0] exp_rx[2][$];
  logic [7:0] sl_q[2][$];
  logic [7:0] bus_q[2][$];
  logic [7:0] txq[2][$];
  int         exp_len[2][$];
  int         exp_n[2][$];

  logic [7:0] tx_buf[16], rx_buf[16];
  int         compared = 0, mismatched = 0;
  bit         fin = 1'b0, fin_ack = 1'b0;

  always #5 clk = ~clk;

  function automatic int dv(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  spi_host #(.CLK_DIV(2)) u_dut0 (
    .clk(clk), .reset(reset[0]), .start(start[0]), .addr(addr[0]), .num_bytes(num_bytes[0]),
    .tx_data(tx_data[0]), .tx_ack(tx_ack[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .busy(busy[0]), .done(done[0]), .cs(cs[0]), .sck(sck[0]), .mosi(mosi[0]), .miso(miso[0]));

  spi_host #(.CLK_DIV(4)) u_dut1 (
    .clk(clk), .reset(reset[1]), .start(start[1]), .addr(addr[1]), .num_bytes(num_bytes[1]),
    .tx_data(tx_data[1]), .tx_ack(tx_ack[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .busy(busy[1]), .done(done[1]), .cs(cs[1]), .sck(sck[1]), .mosi(mosi[1]), .miso(miso[1]));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s (dut%0d): got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endtask

  // tx_data source: presents the head of the byte queue, advances after each tx_ack.
  initial begin : drv
    bit pend_ack[2], pend_rst[2];
    tx_data[0] = 8'h00;
    tx_data[1] = 8'h00;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        pend_ack[k] = tx_ack[k];
        pend_rst[k] = reset[k];
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (pend_rst[k]) txq[k].delete();
        else if (pend_ack[k] && txq[k].size() > 0) void'(txq[k].pop_front());
        tx_data[k] = (txq[k].size() > 0) ? txq[k][0] : 8'h00;
      end
    end
  end

  // Mode-0 peripheral: shifts out on sck fall, captures mosi on sck rise.
  initial begin : periph
    logic       pcs[2], psck[2];
    logic [7:0] sb[2], ib[2];
    int         sbits[2], ibits[2];
    for (int k = 0; k < 2; k++) begin
      pcs[k] = 1'b1; psck[k] = 1'b0; miso[k] = 1'b0;
      sb[k] = 8'h00; ib[k] = 8'h00; sbits[k] = 0; ibits[k] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (pcs[k] === 1'b1 && cs[k] === 1'b0) begin
          sb[k]    = (sl_q[k].size() > 0) ? sl_q[k].pop_front() : 8'h00;
          sbits[k] = 0;
          ibits[k] = 0;
          miso[k]  = sb[k][7];
        end else if (pcs[k] === 1'b0 && cs[k] === 1'b1) begin
          sl_q[k].delete();
        end
        if (cs[k] === 1'b0 && psck[k] === 1'b0 && sck[k] === 1'b1) begin
          ib[k] = {ib[k][6:0], mosi[k]};
          ibits[k]++;
          if (ibits[k] == 8) begin
            bus_q[k].push_back(ib[k]);
            ibits[k] = 0;
          end
        end
        if (cs[k] === 1'b0 && psck[k] === 1'b1 && sck[k] === 1'b0) begin
          sbits[k]++;
          if (sbits[k] == 8) begin
            sbits[k] = 0;
            sb[k]    = (sl_q[k].size() > 0) ? sl_q[k].pop_front() : 8'h00;
          end else begin
            sb[k] = {sb[k][6:0], 1'b0};
          end
          miso[k] = sb[k][7];
        end
        pcs[k]  = cs[k];
        psck[k] = sck[k];
      end
    end
  end

  // Monitor: all comparisons happen here, sampled on the falling clk edge.
  initial begin : mon
    int   busy_cnt[2], ack_cnt[2], rv_cnt[2], rise_cnt[2], cs_low[2], cs_falls[2], bad_runs[2], run_len[2];
    logic psck[2], pcs[2];
    bit   rst_seen[2];
    int   d, len, n;
    for (int k = 0; k < 2; k++) begin
      busy_cnt[k] = 0; ack_cnt[k] = 0; rv_cnt[k] = 0; rise_cnt[k] = 0;
      cs_low[k] = 0; cs_falls[k] = 0; bad_runs[k] = 0; run_len[k] = 0;
      psck[k] = 1'b0; pcs[k] = 1'b1; rst_seen[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        d = dv(k);
        if (reset[k]) begin
          rst_seen[k] = 1'b1;
          busy_cnt[k] = 0; ack_cnt[k] = 0; rv_cnt[k] = 0; rise_cnt[k] = 0;
          cs_low[k] = 0; cs_falls[k] = 0; bad_runs[k] = 0;
          exp_mosi[k].delete(); exp_rx[k].delete(); exp_len[k].delete(); exp_n[k].delete();
          bus_q[k].delete();
        end else begin
          if (rst_seen[k]) begin
            rst_seen[k] = 1'b0;
            chk("reset_state", k, {17'd0, cs[k], sck[k], mosi[k], busy[k], done[k], tx_ack[k], rx_valid[k], rx_data[k]},
                {17'd0, 1'b1, 6'b0, 8'h00});
          end
          if (busy[k]) busy_cnt[k]++;
          if (cs[k] === 1'b0) cs_low[k]++;
          if (pcs[k] === 1'b1 && cs[k] === 1'b0) begin
            cs_falls[k]++;
            run_len[k] = 1;
          end else if (pcs[k] === 1'b0 && cs[k] === 1'b0) begin
            if (sck[k] !== psck[k]) begin
              if (psck[k] === 1'b1) begin
                if (run_len[k] != d) bad_runs[k]++;
              end else begin
                rise_cnt[k]++;
                if (run_len[k] != ((rise_cnt[k] == 1) ? 2 * d : d)) bad_runs[k]++;
              end
              run_len[k] = 1;
            end else begin
              run_len[k]++;
            end
          end
          if (tx_ack[k]) ack_cnt[k]++;
          if (rx_valid[k]) begin
            rv_cnt[k]++;
            if (exp_rx[k].size() == 0) chk("rx_without_expect", k, rv_cnt[k], 0);
            else chk("rx_data", k, rx_data[k], exp_rx[k].pop_front());
          end
          if (busy[k] && exp_len[k].size() > 0 && busy_cnt[k] == exp_len[k][0] + 1)
            chk("txn_length_overrun", k, busy_cnt[k], exp_len[k][0]);
          if (done[k]) begin
            if (exp_len[k].size() == 0) begin
              chk("done_without_txn", k, exp_len[k].size(), 1);
            end else begin
              len = exp_len[k].pop_front();
              n   = exp_n[k].pop_front();
              chk("txn_cycles", k, busy_cnt[k], len);
              chk("tx_ack_count", k, ack_cnt[k], n);
              chk("rx_valid_count", k, rv_cnt[k], n);
              chk("sck_rises", k, rise_cnt[k], 8 * (n + 1));
              chk("cs_low_cycles", k, cs_low[k], d * (2 + 16 * (n + 1)));
              chk("cs_falls", k, cs_falls[k], 1);
              chk("sck_phase_errors", k, bad_runs[k], 0);
              chk("bus_byte_count", k, bus_q[k].size(), n + 1);
              for (int i = 0; i <= n; i++)
                if (bus_q[k].size() > 0 && exp_mosi[k].size() > 0)
                  chk("mosi_byte", k, bus_q[k].pop_front(), exp_mosi[k].pop_front());
            end
            busy_cnt[k] = 0; ack_cnt[k] = 0; rv_cnt[k] = 0; rise_cnt[k] = 0;
            cs_low[k] = 0; cs_falls[k] = 0; bad_runs[k] = 0;
            bus_q[k].delete(); exp_mosi[k].delete(); exp_rx[k].delete();
          end
        end
        psck[k] = sck[k];
        pcs[k]  = cs[k];
      end
      if (fin && !fin_ack) begin
        for (int k = 0; k < 2; k++) chk("pending_txns", k, exp_len[k].size(), 0);
        fin_ack = 1'b1;
      end
    end
  end

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      tx_buf[i] = 8'($urandom);
      rx_buf[i] = 8'($urandom);
    end
  endtask

  // Records the expected outcome, then pulses start for one cycle.
  task automatic issue(input int k, input logic [7:0] a, input int n);
    exp_mosi[k].push_back(a);
    sl_q[k].push_back(8'($urandom));
    for (int i = 0; i < n; i++) begin
      exp_mosi[k].push_back(tx_buf[i]);
      exp_rx[k].push_back(rx_buf[i]);
      sl_q[k].push_back(rx_buf[i]);
      txq[k].push_back(tx_buf[i]);
    end
    exp_len[k].push_back(dv(k) * (3 + 16 * (1 + n)));
    exp_n[k].push_back(n);
    @(posedge clk); #1;
    start[k] = 1'b1; addr[k] = a; num_bytes[k] = 4'(n);
    @(posedge clk); #1;
    start[k] = 1'b0; addr[k] = 8'($urandom); num_bytes[k] = 4'($urandom);
  endtask

  task automatic wait_idle(input int k);
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (!busy[k]) break;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; start[k] = 1'b0; addr[k] = 8'h00; num_bytes[k] = 4'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset[0] = 1'b0; reset[1] = 1'b0;
    repeat (2) @(posedge clk);

    // Address-only frame.
    fill_rand();
    issue(0, 8'h5A, 0);
    wait_idle(0);

    // Two data bytes with fixed payloads.
    tx_buf[0] = 8'hC3; tx_buf[1] = 8'h81; rx_buf[0] = 8'hA5; rx_buf[1] = 8'h3C;
    issue(0, 8'h03, 2);
    wait_idle(0);

    // A second start while busy must be ignored.
    fill_rand();
    issue(0, 8'($urandom), 1);
    repeat (10) @(posedge clk);
    #1;
    start[0] = 1'b1; addr[0] = 8'hFF; num_bytes[0] = 4'd7;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_idle(0);

    // Reset in the middle of the second data byte, then a clean transaction.
    fill_rand();
    issue(0, 8'($urandom), 3);
    repeat (dv(0) * 41) @(posedge clk);
    #1;
    reset[0] = 1'b1;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    repeat (4) @(posedge clk);
    fill_rand();
    issue(0, 8'($urandom), 2);
    wait_idle(0);

    for (int t = 0; t < 4; t++) begin
      fill_rand();
      issue(0, 8'($urandom), $urandom_range(0, 15));
      wait_idle(0);
    end

    // Slower divider, longest frame, then a few random ones.
    fill_rand();
    issue(1, 8'($urandom), 15);
    wait_idle(1);
    for (int t = 0; t < 3; t++) begin
      fill_rand();
      issue(1, 8'($urandom), $urandom_range(0, 15));
      wait_idle(1);
    end

    fin = 1'b1;
    for (int c = 0; c < 100 && !fin_ack; c++) @(negedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
